// File: rtl/truth_table_scanner.sv
// -----------------------------------------------------------------------------
// truth_table_scanner
//
// Sweeps {a,b,c} = 0..7 onto a 3-input combinational block, waits SETTLE
// cycles per row, samples the single-bit response and assembles the 8-row
// truth table. When the sweep finishes, the table is compared with EXPECTED.
//
// Parameters
//   SETTLE    cycles each combination is held before f is sampled (1..255)
//   EXPECTED  reference truth table, bit i = f for {a,b,c} = i
//
// Ports
//   clk_i     clock, all state changes on the rising edge
//   rst_i     synchronous active-high reset
//   start_i   scan request, honoured only while idle (not queued)
//   abc_o     combination driven to the block under test, {a,b,c}
//   f_i       response of the block under test
//   busy_o    high while a scan is in progress
//   done_o    one-cycle pulse after the last row has been sampled
//   table_o   captured truth table, bit i = f sampled for abc = i
//   match_o   table_o == EXPECTED, valid from the done cycle onward
//   state_o   current FSM state (debug visibility)
//
// Handshake: start_i is a level request sampled on each rising edge; a scan
// begins only on an edge where start_i=1 and the FSM is idle. busy_o/done_o
// report progress; there is no back-pressure.
// -----------------------------------------------------------------------------
module truth_table_scanner #(
    parameter int unsigned SETTLE   = 1,
    parameter logic [7:0]  EXPECTED = 8'h70
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    output logic [2:0] abc_o,
    input  logic       f_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] table_o,
    output logic       match_o,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Terminal settle count: the sample is taken on the edge where the
    // counter has already spent SETTLE cycles on the current row.
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

    state_t     state_q, state_d;
    logic [2:0] idx_q,   idx_d;
    logic [7:0] cnt_q,   cnt_d;
    logic [7:0] table_q, table_d;
    logic       match_q, match_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= 8'd0;
            table_q <= 8'h00;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            table_q <= table_d;
            match_q <= match_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        table_d = table_q;
        match_d = match_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = SCAN;
                    idx_d   = 3'd0;
                    cnt_d   = 8'd0;
                    table_d = 8'h00;
                    match_d = 1'b0;
                end
            end
            SCAN: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d          = 8'd0;
                    table_d[idx_q] = f_i;
                    if (idx_q == 3'd7) begin
                        state_d = DONE;
                        // Compare against the table including the row that
                        // is being captured on this very edge.
                        match_d = (table_d == EXPECTED);
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outside a scan the block under test always sees {a,b,c} = 0.
    assign abc_o   = (state_q == SCAN) ? idx_q : 3'd0;
    assign busy_o  = (state_q == SCAN);
    assign done_o  = (state_q == DONE);
    assign table_o = table_q;
    assign match_o = match_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// -----------------------------------------------------------------------------
// tb_truth_table_scanner
//
// Two scanners (SETTLE=1 and SETTLE=3) share clock, reset and start. Each one
// drives its own copy of a lookup-table "device" whose contents the bench
// picks per scan. A timeline model (cycles elapsed since the accepted start)
// predicts every output on every cycle.
// -----------------------------------------------------------------------------
module tb_truth_table_scanner;

  localparam logic [7:0] EXP_TABLE = 8'h70;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] lut;
  logic       glitch;
  logic       glitch_en;
  logic       check_en;

  logic [2:0] abc_w  [2];
  logic       f_w    [2];
  logic       busy_w [2];
  logic       done_w [2];
  logic [7:0] tab_w  [2];
  logic       match_w[2];
  logic [1:0] st_w   [2];

  int n_checks;
  int n_fail;

  // ---------------------------------------------------------------- clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------- DUTs
  truth_table_scanner #(.SETTLE(1), .EXPECTED(EXP_TABLE)) u_dut_s1 (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .abc_o   (abc_w[0]),
    .f_i     (f_w[0]),
    .busy_o  (busy_w[0]),
    .done_o  (done_w[0]),
    .table_o (tab_w[0]),
    .match_o (match_w[0]),
    .state_o (st_w[0])
  );

  truth_table_scanner #(.SETTLE(3), .EXPECTED(EXP_TABLE)) u_dut_s3 (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .abc_o   (abc_w[1]),
    .f_i     (f_w[1]),
    .busy_o  (busy_w[1]),
    .done_o  (done_w[1]),
    .table_o (tab_w[1]),
    .match_o (match_w[1]),
    .state_o (st_w[1])
  );

  // Combinational device under scan: a lookup table, optionally disturbed by
  // a glitch that is confined to the middle of the low... high clock phase.
  assign f_w[0] = lut[abc_w[0]] ^ glitch;
  assign f_w[1] = lut[abc_w[1]] ^ glitch;

  // Glitch window: posedge+2 .. posedge+4, clear before the negedge and well
  // before the next sampling edge.
  initial begin
    glitch = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      glitch = glitch_en ? 1'($urandom_range(0, 1)) : 1'b0;
      #2;
      glitch = 1'b0;
    end
  end

  // ---------------------------------------------------------------- checker
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  // Timeline view: m_t counts edges since the accepted start; the row being
  // driven is m_t / SETTLE and row k is captured when m_t reaches (k+1)*SETTLE.
  int unsigned m_settle[2] = '{1, 3};
  int unsigned m_t     [2];
  bit          m_act   [2];
  bit          m_done  [2];
  logic [7:0]  m_tab   [2];
  bit          m_match [2];

  function automatic logic [2:0] model_abc(input int i);
    return m_act[i] ? 3'(m_t[i] / m_settle[i]) : 3'd0;
  endfunction

  function automatic bit model_idle();
    return !m_act[0] && !m_done[0] && !m_act[1] && !m_done[1];
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_t[i] = 0; m_act[i] = 0; m_done[i] = 0; m_tab[i] = 8'h00; m_match[i] = 0;
    end
  end

  // Outputs at the negedge reflect the previous rising edge; the inputs seen
  // here are the ones the next rising edge will sample.
  always @(negedge clk) begin
    if (check_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("busy[%0d]", i),  {7'd0, busy_w[i]},  {7'd0, m_act[i]});
        check($sformatf("done[%0d]", i),  {7'd0, done_w[i]},  {7'd0, m_done[i]});
        check($sformatf("abc[%0d]", i),   {5'd0, abc_w[i]},   {5'd0, model_abc(i)});
        check($sformatf("table[%0d]", i), tab_w[i],           m_tab[i]);
        check($sformatf("match[%0d]", i), {7'd0, match_w[i]}, {7'd0, m_match[i]});
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_act[i] = 0; m_done[i] = 0; m_t[i] = 0; m_tab[i] = 8'h00; m_match[i] = 0;
      end else if (m_done[i]) begin
        m_done[i] = 0;
      end else if (m_act[i]) begin
        m_t[i]++;
        if (m_t[i] % m_settle[i] == 0) begin
          m_tab[i][m_t[i] / m_settle[i] - 1] = lut[m_t[i] / m_settle[i] - 1];
          if (m_t[i] == 8 * m_settle[i]) begin
            m_act[i]   = 0;
            m_done[i]  = 1;
            m_match[i] = (m_tab[i] == EXP_TABLE);
          end
        end
      end else if (start) begin
        m_act[i] = 1; m_t[i] = 0; m_tab[i] = 8'h00; m_match[i] = 0;
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int len);
    start = 1'b1;
    repeat (len) tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!model_idle() && n < 300) begin
      tick();
      n++;
    end
    if (!model_idle()) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scan did not complete within 300 cycles", name);
    end
    tick();
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    start     = 1'b0;
    lut       = 8'h00;
    glitch_en = 1'b0;
    check_en  = 1'b0;

    tick();
    tick();
    check_en = 1'b1;
    check("reset table", tab_w[0], 8'h00);
    check("reset busy", {7'd0, busy_w[1]}, 8'h00);
    rst = 1'b0;
    tick();

    // f = ~(~a | (b & c)) for every row
    for (int r = 0; r < 8; r++) begin
      logic [2:0] rv;
      rv = 3'(r);
      lut[r] = rv[2] & ~(rv[1] & rv[0]);
    end
    pulse_start(1);
    wait_idle("scan expr");
    check("expr table s1", tab_w[0], 8'h70);
    check("expr match s1", {7'd0, match_w[0]}, 8'h01);
    check("expr table s3", tab_w[1], 8'h70);
    check("expr match s3", {7'd0, match_w[1]}, 8'h01);

    // f = a ^ b ^ c
    for (int r = 0; r < 8; r++) begin
      logic [2:0] rv;
      rv = 3'(r);
      lut[r] = ^rv;
    end
    pulse_start(2);
    wait_idle("scan xor");
    check("xor table s1", tab_w[0], 8'h96);
    check("xor match s1", {7'd0, match_w[0]}, 8'h00);
    check("xor table s3", tab_w[1], 8'h96);

    // Random functions, random start lengths and idle gaps, glitches on.
    glitch_en = 1'b1;
    for (int n = 0; n < 8; n++) begin
      lut = (n == 3) ? EXP_TABLE : 8'($urandom_range(0, 255));
      pulse_start($urandom_range(1, 4));
      wait_idle("scan random");
      repeat ($urandom_range(0, 3)) tick();
    end

    // start held high: scans run back to back, start never restarts a scan.
    lut   = 8'($urandom_range(0, 255));
    start = 1'b1;
    repeat (70) tick();
    start = 1'b0;
    wait_idle("continuous start");

    // Reset after row 4 has been captured by the SETTLE=1 scanner.
    lut = EXP_TABLE;
    pulse_start(1);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst table", tab_w[0], 8'h00);
    check("midrst busy", {7'd0, busy_w[0]}, 8'h00);
    check("midrst abc", {5'd0, abc_w[1]}, 8'h00);
    tick();
    check("midrst no done", {7'd0, done_w[0]}, 8'h00);
    pulse_start(1);
    wait_idle("scan after reset");
    check("post rst table", tab_w[0], 8'h70);
    check("post rst match", {7'd0, match_w[1]}, 8'h01);

    glitch_en = 1'b0;
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
